// File: rtl/lpc_ctrl_pkg.sv
// Shared definitions for the LPC/TPM controller slice.
//   - FSM state encodings for lpc_tpm_ctrl
//   - Field layout of the 32-bit event record queued by lpc_evt_fifo
package lpc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_WAIT = 3'd4
  } ctrl_state_e;

  // Event record: [27:12] addr, [11:4] data, [1:0] type
  localparam int EVT_ADDR_MSB = 27;
  localparam int EVT_ADDR_LSB = 12;
  localparam int EVT_DATA_MSB = 11;
  localparam int EVT_DATA_LSB = 4;
  localparam int EVT_TYPE_MSB = 1;
  localparam int EVT_TYPE_LSB = 0;

  localparam logic [1:0] EVT_TYPE_WR = 2'b01;
  localparam logic [1:0] EVT_TYPE_RD = 2'b11;

  function automatic logic [31:0] evt_pack(input logic [15:0] addr,
                                           input logic [7:0]  data,
                                           input logic [1:0]  typ);
    logic [31:0] rec;
    rec = '0;
    rec[EVT_ADDR_MSB:EVT_ADDR_LSB] = addr;
    rec[EVT_DATA_MSB:EVT_DATA_LSB] = data;
    rec[EVT_TYPE_MSB:EVT_TYPE_LSB] = typ;
    return rec;
  endfunction

endpackage

// File: rtl/lpc_tpm_ctrl_if.sv
// Bus bundle between lpc_tpm_ctrl and its neighbours.
//   Backend register port : reg_req_o/reg_we_o/reg_addr_o/reg_wdata_o out,
//                           reg_ack_i/reg_rdata_i in (rdata valid with ack).
//   Event stream          : evt_valid_o/evt_data_o out, evt_ready_i in.
// master = controller side, slave = backend/consumer side.
interface lpc_tpm_ctrl_if #(
  parameter int AW = 4
);
  logic          reg_req_o;
  logic          reg_we_o;
  logic [AW-1:0] reg_addr_o;
  logic [7:0]    reg_wdata_o;
  logic          reg_ack_i;
  logic [7:0]    reg_rdata_i;

  logic          evt_valid_o;
  logic [31:0]   evt_data_o;
  logic          evt_ready_i;

  modport master (
    output reg_req_o, reg_we_o, reg_addr_o, reg_wdata_o,
    input  reg_ack_i, reg_rdata_i,
    output evt_valid_o, evt_data_o,
    input  evt_ready_i
  );

  modport slave (
    input  reg_req_o, reg_we_o, reg_addr_o, reg_wdata_o,
    output reg_ack_i, reg_rdata_i,
    input  evt_valid_o, evt_data_o,
    output evt_ready_i
  );
endinterface

// File: rtl/lpc_evt_fifo.sv
// Event record FIFO with overflow tracking.
//   push/push_data : write request (dropped when full and not popping)
//   valid/data     : head entry, data stable while valid, zero when empty
//   ready          : consumer accept, pop = valid & ready
//   ovf_clr        : clears overflow flag and drop counter
//   overflow       : sticky, a record was dropped
//   drop_cnt       : saturating count of dropped records
module lpc_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 32
) (
  input  logic          clk_i,
  input  logic          nrst_i,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  output logic          valid,
  output logic [DW-1:0] data,
  input  logic          ready,
  input  logic          ovf_clr,
  output logic          overflow,
  output logic [7:0]    drop_cnt
);
  localparam int PW = $clog2(DEPTH);

  // Extra MSB on each pointer distinguishes full from empty.
  logic [PW:0]   wr_ptr, rd_ptr;
  logic [DW-1:0] mem [DEPTH];
  logic          empty, full, pop, wr_en, drop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign valid = ~empty;
  assign data  = empty ? '0 : mem[rd_ptr[PW-1:0]];
  assign pop   = valid & ready;
  // A pop in the same cycle frees the slot the push lands in.
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_ff @(posedge clk_i or negedge nrst_i)
    if (!nrst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop)   rd_ptr <= rd_ptr + (PW+1)'(1);
    end

  always_ff @(posedge clk_i)
    if (wr_en) mem[wr_ptr[PW-1:0]] <= push_data;

  // Clear wins over accumulation, but a coincident drop is still counted.
  always_ff @(posedge clk_i or negedge nrst_i)
    if (!nrst_i) begin
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end else if (ovf_clr) begin
      overflow <= drop;
      drop_cnt <= drop ? 8'd1 : 8'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
endmodule

// File: rtl/lpc_tpm_ctrl.sv
// Sequences lpc_periph against the TPM register backend.
//   lpc_addr_i/io_rden_i/io_wren_i/lpc_data_in_i : from the peripheral
//   addr_hit_o/din_o                             : back to the peripheral
//   bus (master)                                 : backend port + event stream
//   tdata_i/ready_i                              : cycle records to queue
//   ovf_clr_i/evt_overflow_o/evt_drop_cnt_o      : event drop tracking
//   rd_timeout_o                                 : pulse on backend timeout
module lpc_tpm_ctrl
  import lpc_ctrl_pkg::*;
#(
  parameter logic [15:0] WIN_BASE      = 16'h0000,
  parameter int          WIN_SIZE_LOG2 = 4,
  parameter int          RD_TIMEOUT    = 2,
  parameter int          FIFO_DEPTH    = 4
) (
  input  logic         clk_i,
  input  logic         nrst_i,
  input  logic [15:0]  lpc_addr_i,
  input  logic         io_rden_i,
  input  logic         io_wren_i,
  input  logic [7:0]   lpc_data_in_i,
  input  logic [31:0]  tdata_i,
  input  logic         ready_i,
  output logic         addr_hit_o,
  output logic [7:0]   din_o,
  lpc_tpm_ctrl_if.master bus,
  input  logic         ovf_clr_i,
  output logic         evt_overflow_o,
  output logic [7:0]   evt_drop_cnt_o,
  output logic         rd_timeout_o
);
  localparam int AW = WIN_SIZE_LOG2;
  localparam int CW = $clog2(RD_TIMEOUT + 1);

  ctrl_state_e state, state_nxt;
  logic          rden_q, rden_qq, wren_q, wren_qq, ready_q;
  logic          rd_start, wr_start, busy, is_rd, tmo;
  logic [CW-1:0] cnt;
  logic [AW-1:0] addr_q;
  logic [7:0]    wdata_q;

  assign addr_hit_o = (lpc_addr_i[15:AW] == WIN_BASE[15:AW]);

  // Strobes pass through one register; the edge is taken on the registered copy.
  always_ff @(posedge clk_i or negedge nrst_i)
    if (!nrst_i) {rden_q, rden_qq, wren_q, wren_qq, ready_q} <= '0;
    else begin
      rden_q  <= io_rden_i;
      rden_qq <= rden_q;
      wren_q  <= io_wren_i;
      wren_qq <= wren_q;
      ready_q <= ready_i;
    end

  assign rd_start = rden_q & ~rden_qq & addr_hit_o;
  assign wr_start = wren_q & ~wren_qq & addr_hit_o;
  assign busy     = (state != ST_IDLE);
  assign is_rd    = (state == ST_RD_REQ) || (state == ST_RD_WAIT);
  // cnt = cycles the request has already been held before this one.
  assign tmo      = busy && (cnt == CW'(RD_TIMEOUT - 1));

  // State register
  always_ff @(posedge clk_i or negedge nrst_i)
    if (!nrst_i) state <= ST_IDLE;
    else         state <= state_nxt;

  // Next state; ack is checked first so an ack on the timeout cycle wins.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:
        if (rd_start)      state_nxt = ST_RD_REQ;
        else if (wr_start) state_nxt = ST_WR_REQ;
      ST_RD_REQ, ST_RD_WAIT:
        if (bus.reg_ack_i || tmo) state_nxt = ST_IDLE;
        else                      state_nxt = ST_RD_WAIT;
      ST_WR_REQ, ST_WR_WAIT:
        if (bus.reg_ack_i || tmo) state_nxt = ST_IDLE;
        else                      state_nxt = ST_WR_WAIT;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.reg_req_o   = busy;
    bus.reg_we_o    = (state == ST_WR_REQ) || (state == ST_WR_WAIT);
    bus.reg_addr_o  = addr_q;
    bus.reg_wdata_o = wdata_q;
  end

  // Address/data captured at the start event stay put until ack or timeout.
  always_ff @(posedge clk_i or negedge nrst_i)
    if (!nrst_i) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt          <= '0;
      din_o        <= 8'hFF;
      rd_timeout_o <= 1'b0;
    end else begin
      rd_timeout_o <= tmo & ~bus.reg_ack_i;
      if (!busy) begin
        cnt <= '0;
        if (rd_start || wr_start) addr_q <= lpc_addr_i[AW-1:0];
        if (!rd_start && wr_start) wdata_q <= lpc_data_in_i;
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (is_rd) begin
        if (bus.reg_ack_i) din_o <= bus.reg_rdata_i;
        else if (tmo)      din_o <= 8'hFF;
      end
    end

  lpc_evt_fifo #(.DEPTH(FIFO_DEPTH), .DW(32)) u_fifo (
    .clk_i     (clk_i),
    .nrst_i    (nrst_i),
    .push      (ready_i & ~ready_q),
    .push_data (tdata_i),
    .valid     (bus.evt_valid_o),
    .data      (bus.evt_data_o),
    .ready     (bus.evt_ready_i),
    .ovf_clr   (ovf_clr_i),
    .overflow  (evt_overflow_o),
    .drop_cnt  (evt_drop_cnt_o)
  );
endmodule

// File: tb/tb_lpc_tpm_ctrl.sv
module tb_lpc_tpm_ctrl;
  import lpc_ctrl_pkg::*;

  localparam int RDT = 2;

  logic        clk_i = 1'b0;
  logic        nrst_i = 1'b0;
  logic [15:0] lpc_addr_i = '0;
  logic        io_rden_i = 1'b0, io_wren_i = 1'b0;
  logic [7:0]  lpc_data_in_i = '0;
  logic [31:0] tdata_i = '0;
  logic        ready_i = 1'b0, ovf_clr_i = 1'b0;
  logic        addr_hit_o, evt_overflow_o, rd_timeout_o;
  logic [7:0]  din_o, evt_drop_cnt_o;

  lpc_tpm_ctrl_if #(.AW(4)) bus ();

  lpc_tpm_ctrl #(.WIN_BASE(16'h0000), .WIN_SIZE_LOG2(4), .RD_TIMEOUT(RDT), .FIFO_DEPTH(4)) dut (
    .clk_i          (clk_i),
    .nrst_i         (nrst_i),
    .lpc_addr_i     (lpc_addr_i),
    .io_rden_i      (io_rden_i),
    .io_wren_i      (io_wren_i),
    .lpc_data_in_i  (lpc_data_in_i),
    .tdata_i        (tdata_i),
    .ready_i        (ready_i),
    .addr_hit_o     (addr_hit_o),
    .din_o          (din_o),
    .bus            (bus),
    .ovf_clr_i      (ovf_clr_i),
    .evt_overflow_o (evt_overflow_o),
    .evt_drop_cnt_o (evt_drop_cnt_o),
    .rd_timeout_o   (rd_timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Transaction vectors: inputs then hand-computed expectations.
  typedef struct {
    logic        is_wr;
    logic        both;    // raise io_wren_i together with io_rden_i
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    int          ackd;    // cycles after reg_req_o rise before ack; -1 = never
    logic        exp_hit;
    logic        exp_tmo;
    logic [7:0]  exp_din;
  } txn_t;

  typedef struct {
    logic [15:0] addr;
    logic        exp_hit;
  } dec_t;

  logic [7:0] din_model = 8'hFF;

  task automatic run_txn(input txn_t t, input int idx);
    int e, upd;
    logic exp_req;
    e   = t.exp_tmo ? RDT - 1 : t.ackd;
    upd = t.exp_tmo ? 2 + RDT : 3 + t.ackd;
    lpc_addr_i    = t.addr;
    lpc_data_in_i = t.wdata;
    bus.reg_rdata_i = t.rdata;
    if (t.is_wr) io_wren_i = 1'b1;
    else begin
      io_rden_i = 1'b1;
      if (t.both) io_wren_i = 1'b1;
    end
    for (int c = 1; c <= 6; c++) begin
      step();
      exp_req = t.exp_hit && c >= 2 && c <= 2 + e;
      if (c == 1) chk($sformatf("t%0d_hit", idx), addr_hit_o, t.exp_hit);
      chk($sformatf("t%0d_req_c%0d", idx, c), bus.reg_req_o, exp_req);
      chk($sformatf("t%0d_tmo_c%0d", idx, c), rd_timeout_o,
          t.exp_hit && t.exp_tmo && c == 2 + RDT);
      chk($sformatf("t%0d_din_c%0d", idx, c), din_o,
          (t.exp_hit && c >= upd) ? t.exp_din : din_model);
      if (exp_req) begin
        chk($sformatf("t%0d_addr_c%0d", idx, c), bus.reg_addr_o, t.addr[3:0]);
        chk($sformatf("t%0d_we_c%0d", idx, c), bus.reg_we_o, t.is_wr);
        if (t.is_wr) chk($sformatf("t%0d_wdata_c%0d", idx, c), bus.reg_wdata_o, t.wdata);
      end
      bus.reg_ack_i = t.exp_hit && !t.exp_tmo && c == 2 + t.ackd;
    end
    io_rden_i = 1'b0;
    io_wren_i = 1'b0;
    bus.reg_ack_i = 1'b0;
    din_model = t.exp_din;
    step();
    step();
  endtask

  task automatic push_evt(input logic [31:0] rec, input logic clr, input logic pop);
    tdata_i = rec;
    ready_i = 1'b1;
    ovf_clr_i = clr;
    bus.evt_ready_i = pop;
    step();
    ready_i = 1'b0;
    ovf_clr_i = 1'b0;
    bus.evt_ready_i = 1'b0;
    step();
  endtask

  txn_t txns[8];
  dec_t decs[6];
  logic [31:0] recs[7];

  initial begin
    txns[0] = '{1'b0, 1'b0, 16'h0003, 8'h00, 8'hA5,  0, 1'b1, 1'b0, 8'hA5};
    txns[1] = '{1'b0, 1'b0, 16'h0100, 8'h00, 8'h11,  0, 1'b0, 1'b0, 8'hA5};
    txns[2] = '{1'b0, 1'b0, 16'h0007, 8'h00, 8'h22, -1, 1'b1, 1'b1, 8'hFF};
    txns[3] = '{1'b0, 1'b0, 16'h000F, 8'h00, 8'h5A,  1, 1'b1, 1'b0, 8'h5A};
    txns[4] = '{1'b1, 1'b0, 16'h0002, 8'h3C, 8'h99,  1, 1'b1, 1'b0, 8'h5A};
    txns[5] = '{1'b1, 1'b0, 16'h0009, 8'hC3, 8'h99, -1, 1'b1, 1'b1, 8'h5A};
    txns[6] = '{1'b0, 1'b0, 16'h0010, 8'h00, 8'h33,  0, 1'b0, 1'b0, 8'h5A};
    txns[7] = '{1'b0, 1'b1, 16'h0000, 8'h77, 8'h00,  0, 1'b1, 1'b0, 8'h00};
    decs[0] = '{16'h0000, 1'b1};
    decs[1] = '{16'h000F, 1'b1};
    decs[2] = '{16'h0010, 1'b0};
    decs[3] = '{16'h0100, 1'b0};
    decs[4] = '{16'h8000, 1'b0};
    decs[5] = '{16'hFFFF, 1'b0};
    for (int i = 0; i < 7; i++)
      recs[i] = evt_pack(16'h0040 + 16'(i), 8'h10 * 8'(i) + 8'h1, (i % 2 == 0) ? EVT_TYPE_RD : EVT_TYPE_WR);

    bus.reg_ack_i = 1'b0;
    bus.reg_rdata_i = '0;
    bus.evt_ready_i = 1'b0;

    // Reset values
    #12;
    chk("rst_din", din_o, 8'hFF);
    chk("rst_req", bus.reg_req_o, 1'b0);
    chk("rst_we", bus.reg_we_o, 1'b0);
    chk("rst_addr", bus.reg_addr_o, 4'h0);
    chk("rst_wdata", bus.reg_wdata_o, 8'h00);
    chk("rst_evt_valid", bus.evt_valid_o, 1'b0);
    chk("rst_evt_data", bus.evt_data_o, 32'h0);
    chk("rst_ovf", evt_overflow_o, 1'b0);
    chk("rst_drop", evt_drop_cnt_o, 8'h00);
    chk("rst_tmo", rd_timeout_o, 1'b0);
    nrst_i = 1'b1;
    step();

    // Address decode
    foreach (decs[i]) begin
      lpc_addr_i = decs[i].addr;
      #1;
      chk($sformatf("dec%0d", i), addr_hit_o, decs[i].exp_hit);
    end
    step();

    foreach (txns[i]) run_txn(txns[i], i);

    // Event FIFO: fill, overflow by one
    chk("fifo_empty", bus.evt_valid_o, 1'b0);
    tdata_i = recs[0];
    ready_i = 1'b1;
    step();
    chk("fifo_lat_valid", bus.evt_valid_o, 1'b1);
    chk("fifo_lat_data", bus.evt_data_o, recs[0]);
    ready_i = 1'b0;
    step();
    for (int i = 1; i < 5; i++) push_evt(recs[i], 1'b0, 1'b0);
    chk("fifo_ovf", evt_overflow_o, 1'b1);
    chk("fifo_drop1", evt_drop_cnt_o, 8'd1);
    chk("fifo_head", bus.evt_data_o, recs[0]);
    ovf_clr_i = 1'b1;
    step();
    ovf_clr_i = 1'b0;
    chk("clr_ovf", evt_overflow_o, 1'b0);
    chk("clr_drop", evt_drop_cnt_o, 8'd0);
    // Clear coincident with a drop
    push_evt(recs[5], 1'b1, 1'b0);
    chk("clrdrop_ovf", evt_overflow_o, 1'b1);
    chk("clrdrop_cnt", evt_drop_cnt_o, 8'd1);
    ovf_clr_i = 1'b1;
    step();
    ovf_clr_i = 1'b0;
    // Push while full with a pop in the same cycle
    push_evt(recs[6], 1'b0, 1'b1);
    chk("fullpop_drop", evt_drop_cnt_o, 8'd0);
    chk("fullpop_ovf", evt_overflow_o, 1'b0);
    chk("fullpop_head", bus.evt_data_o, recs[1]);
    // Drain
    bus.evt_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_valid", i), bus.evt_valid_o, 1'b1);
      chk($sformatf("drain%0d_data", i), bus.evt_data_o, (i == 3) ? recs[6] : recs[i+1]);
      step();
    end
    chk("drain_empty", bus.evt_valid_o, 1'b0);
    bus.evt_ready_i = 1'b0;

    // Async reset in RD_WAIT
    push_evt(recs[2], 1'b0, 1'b0);
    lpc_addr_i = 16'h0005;
    io_rden_i = 1'b1;
    step(); step(); step();
    chk("ar_req_before", bus.reg_req_o, 1'b1);
    #2 nrst_i = 1'b0;
    #1;
    chk("ar_req", bus.reg_req_o, 1'b0);
    chk("ar_din", din_o, 8'hFF);
    chk("ar_fifo", bus.evt_valid_o, 1'b0);
    io_rden_i = 1'b0;
    #3 nrst_i = 1'b1;
    step(); step();
    din_model = 8'hFF;
    run_txn('{1'b0, 1'b0, 16'h0003, 8'h00, 8'h77, 0, 1'b1, 1'b0, 8'h77}, 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
